// File: rtl/rv64_exu.sv
// rv64_exu: execute stage of the 5-stage RV64IM pipeline.
// Forwards the operands, computes the ALU/compare/mul-div result, the jump or branch
// target dnpc and the forwarded store data wdata. The datapath is purely combinational.
// Optional feature macro: EXU_M_EXT_EN. When it is defined, the multiplier and divider
// (ALUop 16-23) are built. When it is undefined, those ops return 0.
module rv64_exu #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [10:0]     ctrl_ex,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1data,
    input  logic [XLEN-1:0] rs2data,
    input  logic [XLEN-1:0] csrdata,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      forward_ALUSrc1,
    input  logic [1:0]      forward_ALUSrc2,
    input  logic [XLEN-1:0] forward_data_mem,
    input  logic [XLEN-1:0] forward_data_wb,
    input  logic [1:0]      forward_wdataSrc,
    input  logic [XLEN-1:0] forward_wdata_mem,
    input  logic [XLEN-1:0] forward_wdata_wb,
    output logic [XLEN-1:0] dnpc,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] wdata
);

    localparam logic [4:0] OpAdd    = 5'd0;
    localparam logic [4:0] OpSub    = 5'd1;
    localparam logic [4:0] OpSll    = 5'd2;
    localparam logic [4:0] OpSlt    = 5'd3;
    localparam logic [4:0] OpSltu   = 5'd4;
    localparam logic [4:0] OpXor    = 5'd5;
    localparam logic [4:0] OpSrl    = 5'd6;
    localparam logic [4:0] OpSra    = 5'd7;
    localparam logic [4:0] OpOr     = 5'd8;
    localparam logic [4:0] OpAnd    = 5'd9;
    localparam logic [4:0] OpEq     = 5'd10;
    localparam logic [4:0] OpNe     = 5'd11;
    localparam logic [4:0] OpLt     = 5'd12;
    localparam logic [4:0] OpGe     = 5'd13;
    localparam logic [4:0] OpLtu    = 5'd14;
    localparam logic [4:0] OpGeu    = 5'd15;
    localparam logic [4:0] OpPassB  = 5'd24;
    localparam logic [4:0] OpAndn   = 5'd25;
`ifdef EXU_M_EXT_EN
    localparam logic [4:0] OpMul    = 5'd16;
    localparam logic [4:0] OpMulh   = 5'd17;
    localparam logic [4:0] OpMulhsu = 5'd18;
    localparam logic [4:0] OpMulhu  = 5'd19;
    localparam logic [4:0] OpDiv    = 5'd20;
    localparam logic [4:0] OpDivu   = 5'd21;
    localparam logic [4:0] OpRem    = 5'd22;
    localparam logic [4:0] OpRemu   = 5'd23;
`endif

    // Clock and reset exist only for interface uniformity.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    logic       npc_src;
    logic       alu_sext;
    logic       add_src;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic [4:0] alu_op;

    assign npc_src  = ctrl_ex[10];
    assign alu_sext = ctrl_ex[9];
    assign add_src  = ctrl_ex[8];
    assign alu_src1 = ctrl_ex[7];
    assign alu_src2 = ctrl_ex[6:5];
    assign alu_op   = ctrl_ex[4:0];

    logic [63:0] f1, f2, op_a, op_b;

    // Forwarding muxes and operand selection.
    always_comb begin
        unique case (forward_ALUSrc1)
            2'd1:    f1 = forward_data_wb;
            2'd2:    f1 = forward_data_mem;
            default: f1 = rs1data;
        endcase
        unique case (forward_ALUSrc2)
            2'd1:    f2 = forward_data_wb;
            2'd2:    f2 = forward_data_mem;
            default: f2 = rs2data;
        endcase
        unique case (forward_wdataSrc)
            2'd1:    wdata = forward_wdata_wb;
            2'd2:    wdata = forward_wdata_mem;
            default: wdata = rs2data;
        endcase
        op_a = alu_src1 ? pc : f1;
        unique case (alu_src2)
            2'd0:    op_b = f2;
            2'd1:    op_b = imm;
            2'd2:    op_b = csrdata;
            default: op_b = 64'd4;
        endcase
    end

    logic [5:0]  shamt;
    logic [63:0] srl_src, sra_src;

    // W-form shifts use a 5-bit amount on the low word, extended per shift kind.
    always_comb begin
        shamt   = alu_sext ? {1'b0, op_b[4:0]} : op_b[5:0];
        srl_src = alu_sext ? {32'b0, op_a[31:0]} : op_a;
        sra_src = alu_sext ? {{32{op_a[31]}}, op_a[31:0]} : op_a;
    end

`ifdef EXU_M_EXT_EN
    logic [127:0] mul_a, mul_b, mul_p;
    logic         div_signed;
    logic [63:0]  dvd, dvs, quot, rem;

    // Single 128-bit multiplier; operand extension selects mulh/mulhsu/mulhu.
    always_comb begin
        mul_a = {{64{op_a[63] & ((alu_op == OpMulh) || (alu_op == OpMulhsu))}}, op_a};
        mul_b = {{64{op_b[63] & (alu_op == OpMulh)}}, op_b};
        mul_p = mul_a * mul_b;
    end

    // Divider. W-forms divide the extended low words, so the 32-bit overflow case
    // falls out naturally once the result is sign-extended from bit 31.
    always_comb begin
        div_signed = (alu_op == OpDiv) || (alu_op == OpRem);
        if (alu_sext) begin
            dvd = div_signed ? {{32{op_a[31]}}, op_a[31:0]} : {32'b0, op_a[31:0]};
            dvs = div_signed ? {{32{op_b[31]}}, op_b[31:0]} : {32'b0, op_b[31:0]};
        end else begin
            dvd = op_a;
            dvs = op_b;
        end
        if (dvs == 64'd0) begin
            quot = '1;
            rem  = dvd;
        end else if (div_signed && dvd == 64'h8000_0000_0000_0000 && dvs == '1) begin
            quot = dvd;
            rem  = 64'd0;
        end else if (div_signed) begin
            quot = $signed(dvd) / $signed(dvs);
            rem  = $signed(dvd) % $signed(dvs);
        end else begin
            quot = dvd / dvs;
            rem  = dvd % dvs;
        end
    end
`endif

    logic [63:0] alu_res;
    logic        is_cmp;

    // ALU operation decode.
    always_comb begin
        alu_res = 64'd0;
        unique case (alu_op)
            OpAdd:    alu_res = op_a + op_b;
            OpSub:    alu_res = op_a - op_b;
            OpSll:    alu_res = op_a << shamt;
            OpSlt:    alu_res = {63'b0, $signed(op_a) < $signed(op_b)};
            OpSltu:   alu_res = {63'b0, op_a < op_b};
            OpXor:    alu_res = op_a ^ op_b;
            OpSrl:    alu_res = srl_src >> shamt;
            OpSra:    alu_res = $signed(sra_src) >>> shamt;
            OpOr:     alu_res = op_a | op_b;
            OpAnd:    alu_res = op_a & op_b;
            OpEq:     alu_res = {63'b0, op_a == op_b};
            OpNe:     alu_res = {63'b0, op_a != op_b};
            OpLt:     alu_res = {63'b0, $signed(op_a) < $signed(op_b)};
            OpGe:     alu_res = {63'b0, $signed(op_a) >= $signed(op_b)};
            OpLtu:    alu_res = {63'b0, op_a < op_b};
            OpGeu:    alu_res = {63'b0, op_a >= op_b};
`ifdef EXU_M_EXT_EN
            OpMul:    alu_res = mul_p[63:0];
            OpMulh:   alu_res = mul_p[127:64];
            OpMulhsu: alu_res = mul_p[127:64];
            OpMulhu:  alu_res = mul_p[127:64];
            OpDiv:    alu_res = quot;
            OpDivu:   alu_res = quot;
            OpRem:    alu_res = rem;
            OpRemu:   alu_res = rem;
`endif
            OpPassB:  alu_res = op_b;
            OpAndn:   alu_res = op_b & ~op_a;
            default:  alu_res = 64'd0;
        endcase
    end

    // Final result: W-form sign extension (not for compares), then link override.
    always_comb begin
        is_cmp = (alu_op >= OpEq) && (alu_op <= OpGeu);
        if (add_src) begin
            result = pc + 64'd4;
        end else if (alu_sext && !is_cmp) begin
            result = {{32{alu_res[31]}}, alu_res[31:0]};
        end else begin
            result = alu_res;
        end
    end

    // Jump/branch target; jalr clears bit 0.
    always_comb begin
        if (npc_src) begin
            dnpc = (f1 + imm) & ~64'h1;
        end else begin
            dnpc = pc + imm;
        end
    end

endmodule

// File: tb/tb_rv64_exu.sv
// tb_rv64_exu: directed and randomized checks of rv64_exu against a behavioural model.
module tb_rv64_exu;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] ctrl_ex;
    logic [63:0] pc, rs1data, rs2data, csrdata, imm;
    logic [1:0]  forward_ALUSrc1, forward_ALUSrc2, forward_wdataSrc;
    logic [63:0] forward_data_mem, forward_data_wb, forward_wdata_mem, forward_wdata_wb;
    logic [63:0] dnpc, result, wdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv64_exu #(.XLEN(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .ctrl_ex           (ctrl_ex),
        .pc                (pc),
        .rs1data           (rs1data),
        .rs2data           (rs2data),
        .csrdata           (csrdata),
        .imm               (imm),
        .forward_ALUSrc1   (forward_ALUSrc1),
        .forward_ALUSrc2   (forward_ALUSrc2),
        .forward_data_mem  (forward_data_mem),
        .forward_data_wb   (forward_data_wb),
        .forward_wdataSrc  (forward_wdataSrc),
        .forward_wdata_mem (forward_wdata_mem),
        .forward_wdata_wb  (forward_wdata_wb),
        .dnpc              (dnpc),
        .result            (result),
        .wdata             (wdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_ctrl(input logic npc, input logic sext, input logic adds,
                                            input logic src1, input logic [1:0] src2,
                                            input logic [4:0] op);
        return {npc, sext, adds, src1, src2, op};
    endfunction

    task automatic clear_inputs();
        ctrl_ex = '0; pc = '0; rs1data = '0; rs2data = '0; csrdata = '0; imm = '0;
        forward_ALUSrc1 = '0; forward_ALUSrc2 = '0; forward_wdataSrc = '0;
        forward_data_mem = '0; forward_data_wb = '0; forward_wdata_mem = '0;
        forward_wdata_wb = '0;
    endtask

    // Sample well away from the clock edge.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] pick_fwd(input logic [1:0] sel, input logic [63:0] regv,
                                             input logic [63:0] wb, input logic [63:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return regv;
    endfunction

    // Behavioural reference: arithmetic written with native signed/unsigned integer types.
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        longint              sa, sb, sq;
        int                  a32, b32, q32;
        int unsigned         ua32, ub32;
        logic signed [127:0] pa, pb, pbu, ps;
        logic [127:0]        pu;
        logic [63:0]         r;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        pa = sa; pb = sb; pbu = {64'b0, b};
        r = 64'd0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  if (w) r = a << b[4:0]; else r = a << b[5:0];
            5'd3:  r = {63'b0, sa < sb};
            5'd4:  r = {63'b0, a < b};
            5'd5:  r = a ^ b;
            5'd6:  if (w) r = {32'b0, ua32 >> b[4:0]}; else r = a >> b[5:0];
            5'd7:  begin
                if (w) begin
                    q32 = a32 >>> b[4:0];
                    r = {{32{q32[31]}}, q32};
                end else begin
                    sq = sa >>> b[5:0];
                    r = sq;
                end
            end
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: r = {63'b0, a == b};
            5'd11: r = {63'b0, a != b};
            5'd12: r = {63'b0, sa < sb};
            5'd13: r = {63'b0, sa >= sb};
            5'd14: r = {63'b0, a < b};
            5'd15: r = {63'b0, a >= b};
`ifdef EXU_M_EXT_EN
            5'd16: r = a * b;
            5'd17: begin ps = pa * pb;  r = ps[127:64]; end
            5'd18: begin ps = pa * pbu; r = ps[127:64]; end
            5'd19: begin pu = {64'b0, a} * {64'b0, b}; r = pu[127:64]; end
            5'd20, 5'd22: begin
                if (w) begin
                    if (b32 == 0) q32 = (op == 5'd20) ? -1 : a32;
                    else if (a32 == 32'h8000_0000 && b32 == -1) q32 = (op == 5'd20) ? a32 : 0;
                    else q32 = (op == 5'd20) ? a32 / b32 : a32 % b32;
                    r = {{32{q32[31]}}, q32};
                end else begin
                    if (sb == 0) sq = (op == 5'd20) ? -64'sd1 : sa;
                    else if (a == 64'h8000_0000_0000_0000 && sb == -1)
                        sq = (op == 5'd20) ? sa : 64'sd0;
                    else sq = (op == 5'd20) ? sa / sb : sa % sb;
                    r = sq;
                end
            end
            5'd21, 5'd23: begin
                if (w) begin
                    if (ub32 == 0) r = (op == 5'd21) ? 64'hFFFF_FFFF : {32'b0, ua32};
                    else r = {32'b0, (op == 5'd21) ? ua32 / ub32 : ua32 % ub32};
                end else begin
                    if (b == 0) r = (op == 5'd21) ? '1 : a;
                    else r = (op == 5'd21) ? a / b : a % b;
                end
            end
`endif
            5'd24: r = b;
            5'd25: r = b & ~a;
            default: r = 64'd0;
        endcase
        if (w && !(op >= 5'd10 && op <= 5'd15)) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    task automatic check_model(input string tag);
        logic [63:0] f1, f2, a, b, exp_res, exp_npc;
        f1 = pick_fwd(forward_ALUSrc1, rs1data, forward_data_wb, forward_data_mem);
        f2 = pick_fwd(forward_ALUSrc2, rs2data, forward_data_wb, forward_data_mem);
        a  = ctrl_ex[7] ? pc : f1;
        case (ctrl_ex[6:5])
            2'd0:    b = f2;
            2'd1:    b = imm;
            2'd2:    b = csrdata;
            default: b = 64'd4;
        endcase
        if (ctrl_ex[8]) exp_res = pc + 64'd4;
        else exp_res = ref_alu(ctrl_ex[4:0], ctrl_ex[9], a, b);
        if (ctrl_ex[10]) exp_npc = (f1 + imm) & ~64'h1;
        else exp_npc = pc + imm;
        check_eq({tag, ".result"}, result, exp_res);
        check_eq({tag, ".dnpc"}, dnpc, exp_npc);
        check_eq({tag, ".wdata"}, wdata,
                 pick_fwd(forward_wdataSrc, rs2data, forward_wdata_wb, forward_wdata_mem));
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'h0000_0000_8000_0000;
            5:       return 64'h0000_0000_7FFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [63:0] m_div0, m_rem0, m_ovf, m_mulhu;

    initial begin
`ifdef EXU_M_EXT_EN
        m_div0 = '1; m_rem0 = 64'd7; m_ovf = 64'h8000_0000_0000_0000;
        m_mulhu = 64'hFFFF_FFFF_FFFF_FFFE;
`else
        m_div0 = '0; m_rem0 = '0; m_ovf = '0; m_mulhu = '0;
`endif
        rst = 1'b1;
        clear_inputs();
        settle();
        check_eq("reset.result", result, 64'd0);
        check_eq("reset.dnpc", dnpc, 64'd0);
        check_eq("reset.wdata", wdata, 64'd0);
        rst = 1'b0;

        clear_inputs(); ctrl_ex = mk_ctrl(0, 0, 0, 0, 2'd1, 5'd0);
        rs1data = 64'd5; imm = -64'sd3; settle();
        check_eq("add_imm", result, 64'd2);

        clear_inputs(); ctrl_ex = mk_ctrl(0, 0, 0, 0, 2'd0, 5'd1);
        rs2data = 64'd1; settle();
        check_eq("sub_neg", result, '1);

        clear_inputs(); ctrl_ex = mk_ctrl(0, 0, 0, 0, 2'd1, 5'd0);
        forward_ALUSrc1 = 2'd2; forward_data_mem = 64'h100; rs1data = 64'h1; imm = 64'd8;
        settle();
        check_eq("fwd_mem", result, 64'h108);
        forward_ALUSrc1 = 2'd1; forward_data_wb = 64'h200; settle();
        check_eq("fwd_wb", result, 64'h208);

        clear_inputs(); ctrl_ex = mk_ctrl(1, 0, 1, 0, 2'd1, 5'd0);
        rs1data = 64'h8000_0003; imm = 64'd4; pc = 64'h8000_0000; settle();
        check_eq("jalr_dnpc", dnpc, 64'h8000_0006);
        check_eq("jalr_link", result, 64'h8000_0004);

        clear_inputs(); ctrl_ex = mk_ctrl(0, 0, 0, 0, 2'd0, 5'd12);
        rs1data = '1; settle();
        check_eq("blt", result, 64'd1);
        ctrl_ex = mk_ctrl(0, 0, 0, 0, 2'd0, 5'd14); settle();
        check_eq("bltu", result, 64'd0);

        clear_inputs(); pc = 64'h8000_0010; imm = -64'sd16; settle();
        check_eq("br_dnpc", dnpc, 64'h8000_0000);

        clear_inputs(); ctrl_ex = mk_ctrl(0, 1, 0, 0, 2'd1, 5'd0);
        rs1data = 64'h7FFF_FFFF; imm = 64'd1; settle();
        check_eq("addw", result, 64'hFFFF_FFFF_8000_0000);
        ctrl_ex = mk_ctrl(0, 1, 0, 0, 2'd1, 5'd7); rs1data = 64'h8000_0000; imm = 64'd4;
        settle();
        check_eq("sraw", result, 64'hFFFF_FFFF_F800_0000);

        clear_inputs(); ctrl_ex = mk_ctrl(0, 0, 0, 0, 2'd0, 5'd20);
        rs1data = 64'd5; settle();
        check_eq("div_by0", result, m_div0);
        ctrl_ex = mk_ctrl(0, 0, 0, 0, 2'd0, 5'd22); rs1data = 64'd7; settle();
        check_eq("rem_by0", result, m_rem0);
        ctrl_ex = mk_ctrl(0, 0, 0, 0, 2'd0, 5'd20);
        rs1data = 64'h8000_0000_0000_0000; rs2data = '1; settle();
        check_eq("div_ovf", result, m_ovf);
        ctrl_ex = mk_ctrl(0, 0, 0, 0, 2'd0, 5'd19); rs1data = '1; settle();
        check_eq("mulhu", result, m_mulhu);

        clear_inputs(); rs2data = 64'h55; forward_wdata_mem = 64'hAB;
        forward_wdata_wb = 64'hCD; forward_wdataSrc = 2'd2; settle();
        check_eq("wdata_mem", wdata, 64'hAB);
        forward_wdataSrc = 2'd0; settle();
        check_eq("wdata_reg0", wdata, 64'h55);
        forward_wdataSrc = 2'd3; settle();
        check_eq("wdata_reg3", wdata, 64'h55);
        forward_wdataSrc = 2'd1; settle();
        check_eq("wdata_wb", wdata, 64'hCD);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 15) == 0);
            ctrl_ex = 11'($urandom);
            pc = rnd64(); rs1data = rnd64(); rs2data = rnd64(); csrdata = rnd64();
            imm = rnd64();
            forward_ALUSrc1 = 2'($urandom); forward_ALUSrc2 = 2'($urandom);
            forward_wdataSrc = 2'($urandom);
            forward_data_mem = rnd64(); forward_data_wb = rnd64();
            forward_wdata_mem = rnd64(); forward_wdata_wb = rnd64();
            settle();
            check_model($sformatf("rnd%0d_op%0d", i, ctrl_ex[4:0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
